// File: rtl/bcd_pkg.sv
// Shared types and constant helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle  = 2'd0;
  localparam state_t StShift = 2'd1;
  localparam state_t StDone  = 2'd2;

  // 10^n, used to derive the saturation threshold at elaboration time
  function automatic int unsigned pow10(input int unsigned n);
    int unsigned p;
    p = 1;
    for (int unsigned i = 0; i < n; i++) begin
      p = p * 10;
    end
    return p;
  endfunction

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction cell: adds 3 to a BCD digit that is 5 or more.
module bcd_digit_adj (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  always_comb begin
    digit_o = digit_i;
    if (digit_i >= 4'd5) begin
      digit_o = digit_i + 4'd3;
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative shift-and-add-3 binary-to-BCD converter with start/valid handshake,
// leading-zero blanking mask and saturation when the value does not fit in DIGITS.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [BIN_W-1:0]      bin_i,
  output logic                  busy_o,
  output logic                  valid_o,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic [DIGITS-1:0]     blank_o,
  output logic                  ovf_o
);

  localparam int unsigned AccW   = 4 * DIGITS;
  localparam int unsigned CntW   = clog2(BIN_W + 1);
  localparam int unsigned MaxVal = pow10(DIGITS) - 1;

  localparam logic [AccW-1:0]   AllNines = {DIGITS{4'h9}};
  // Reset mask blanks every digit except the ones digit
  localparam logic [DIGITS-1:0] BlankRst = ~DIGITS'(1);

  state_t            state_q, state_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic [AccW-1:0]   acc_q, acc_d;
  logic [AccW-1:0]   acc_adj;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [AccW-1:0]   bcd_q, bcd_d;
  logic [DIGITS-1:0] blank_q, blank_d;
  logic              ovf_out_q, ovf_out_d;
  logic              valid_q, valid_d;
  logic [AccW-1:0]   result;
  logic [DIGITS-1:0] blank_calc;
  logic              nonzero_above;

  for (genvar k = 0; k < int'(DIGITS); k++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (acc_q[4*k +: 4]),
      .digit_o (acc_adj[4*k +: 4])
    );
  end

  assign result = ovf_q ? AllNines : acc_q;

  // A digit is blanked only when it and every more-significant digit are zero
  always_comb begin
    nonzero_above = 1'b0;
    blank_calc    = '0;
    for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
      nonzero_above = nonzero_above | (result[4*k +: 4] != 4'd0);
      blank_calc[k] = ~nonzero_above;
    end
  end

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    bcd_d     = bcd_q;
    blank_d   = blank_q;
    ovf_out_d = ovf_out_q;
    valid_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          bin_d   = bin_i;
          acc_d   = '0;
          cnt_d   = CntW'(BIN_W);
          ovf_d   = 32'(bin_i) > MaxVal;
          state_d = StShift;
        end
      end
      StShift: begin
        acc_d = (acc_adj << 1) | AccW'(bin_q[BIN_W-1]);
        bin_d = bin_q << 1;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        bcd_d     = result;
        blank_d   = ovf_q ? '0 : blank_calc;
        ovf_out_d = ovf_q;
        valid_d   = 1'b1;
        state_d   = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      bin_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      bcd_q     <= '0;
      blank_q   <= BlankRst;
      ovf_out_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      bcd_q     <= bcd_d;
      blank_q   <= blank_d;
      ovf_out_q <= ovf_out_d;
      valid_q   <= valid_d;
    end
  end

  assign busy_o  = (state_q == StShift);
  assign valid_o = valid_q;
  assign bcd_o   = bcd_q;
  assign blank_o = blank_q;
  assign ovf_o   = ovf_out_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: two instances (2 and 3 digits) checked against a decimal model.
module tb_bin_to_bcd_seq;

  logic        clk, rst;
  logic        start_a, start_b;
  logic [7:0]  bin_a, bin_b;
  logic        busy_a, valid_a, ovf_a;
  logic [7:0]  bcd_a;
  logic [1:0]  blank_a;
  logic        busy_b, valid_b, ovf_b;
  logic [11:0] bcd_b;
  logic [2:0]  blank_b;

  int nvec = 0;
  int nerr = 0;
  int pulses_a = 0;
  int pulses_b = 0;
  int exp_a = 0;
  int exp_b = 0;

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) dut_a (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start_a),
    .bin_i   (bin_a),
    .busy_o  (busy_a),
    .valid_o (valid_a),
    .bcd_o   (bcd_a),
    .blank_o (blank_a),
    .ovf_o   (ovf_a)
  );

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut_b (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start_b),
    .bin_i   (bin_b),
    .busy_o  (busy_b),
    .valid_o (valid_b),
    .bcd_o   (bcd_b),
    .blank_o (blank_b),
    .ovf_o   (ovf_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (valid_a) pulses_a++;
    if (valid_b) pulses_b++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned p10(input int unsigned n);
    int unsigned p = 1;
    repeat (n) p = p * 10;
    return p;
  endfunction

  // Decimal digits of v, saturated to the largest displayable value
  function automatic logic [31:0] ref_bcd(input int unsigned v, input int unsigned d);
    logic [31:0] r = '0;
    int unsigned t = (v >= p10(d)) ? p10(d) - 1 : v;
    for (int k = 0; k < int'(d); k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [31:0] ref_blank(input int unsigned v, input int unsigned d);
    logic [31:0] r = '0;
    if (v < p10(d)) begin
      for (int k = 1; k < int'(d); k++) r[k] = (v < p10(k));
    end
    return r;
  endfunction

  // Start a conversion on the selected instance and check latency, busy width and result.
  // poke_at >= 0 pulses start_i with value 11 at that cycle after acceptance.
  task automatic run(input bit sel, input int unsigned v, input int poke_at, input string tag);
    int lat = -1;
    int busy_n = 0;
    int unsigned d = sel ? 3 : 2;
    logic [31:0] bcd_obs, blank_obs, ovf_obs;
    if (sel) begin start_b = 1'b1; bin_b = 8'(v); end
    else begin start_a = 1'b1; bin_a = 8'(v); end
    @(posedge clk);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (sel) begin
        start_b = (i == poke_at);
        if (i == poke_at) bin_b = 8'd11;
      end else begin
        start_a = (i == poke_at);
        if (i == poke_at) bin_a = 8'd11;
      end
      if (sel ? busy_b : busy_a) busy_n++;
      if (sel ? valid_b : valid_a) begin
        lat = i;
        break;
      end
    end
    if (sel) exp_b++; else exp_a++;
    bcd_obs   = sel ? 32'(bcd_b) : 32'(bcd_a);
    blank_obs = sel ? 32'(blank_b) : 32'(blank_a);
    ovf_obs   = sel ? 32'(ovf_b) : 32'(ovf_a);
    chk({tag, ".latency"}, 32'(lat), 32'd9);
    chk({tag, ".busy_cycles"}, 32'(busy_n), 32'd8);
    chk({tag, ".bcd"}, bcd_obs, ref_bcd(v, d));
    chk({tag, ".blank"}, blank_obs, ref_blank(v, d));
    chk({tag, ".ovf"}, ovf_obs, 32'(v >= p10(d)));
  endtask

  initial begin
    rst = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    bin_a = '0;
    bin_b = '0;
    #12;
    chk("rst.busy", 32'(busy_a), 32'd0);
    chk("rst.valid", 32'(valid_a), 32'd0);
    chk("rst.bcd", 32'(bcd_a), 32'd0);
    chk("rst.blank", 32'(blank_a), 32'b10);
    chk("rst.ovf", 32'(ovf_a), 32'd0);
    chk("rst.blank3", 32'(blank_b), 32'b110);
    #8;
    rst = 1'b0;

    run(1'b0, 42, -1, "v42");
    run(1'b0, 0, -1, "v0");
    run(1'b0, 5, -1, "v5");
    run(1'b0, 15, -1, "v15");
    run(1'b0, 99, -1, "v99");
    run(1'b0, 100, -1, "ovf100");
    run(1'b0, 255, -1, "ovf255");
    run(1'b0, 73, -1, "after_ovf73");
    run(1'b1, 255, -1, "d3_255");
    run(1'b1, 7, -1, "d3_7");
    run(1'b0, 42, 3, "poke_busy");
    run(1'b0, 42, 8, "poke_done");

    // Abort a conversion of 99 during its 4th shift cycle
    start_a = 1'b1;
    bin_a = 8'd99;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort.busy", 32'(busy_a), 32'd0);
    chk("abort.valid", 32'(valid_a), 32'd0);
    chk("abort.bcd", 32'(bcd_a), 32'd0);
    chk("abort.blank", 32'(blank_a), 32'b10);
    chk("abort.ovf", 32'(ovf_a), 32'd0);
    chk("abort.bcd3", 32'(bcd_b), 32'd0);
    #9;
    rst = 1'b0;
    repeat (15) @(negedge clk);
    chk("abort.no_valid", 32'(pulses_a), 32'(exp_a));
    run(1'b0, 73, -1, "post_abort73");

    for (int n = 0; n < 16; n++) begin
      run(1'(n % 2), $urandom_range(0, 255), -1, "rnd");
    end

    @(negedge clk);
    chk("pulses_a", 32'(pulses_a), 32'(exp_a));
    chk("pulses_b", 32'(pulses_b), 32'(exp_b));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
